// File: rtl/spi_master_command8_address16_data32.sv
// SPI mode-0 master: one 56-bit {command8, address16, data32} frame per start.
// Captures the 32 reply bits of the data phase and flags them with done.
module spi_master_command8_address16_data32 #(
    parameter int CLOCK_DIVIDE     = 4,
    parameter int GAP_HALF_PERIODS = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  command8,
    input  logic [15:0] address16,
    input  logic [31:0] data32,
    output logic        busy,
    output logic        done,
    output logic [31:0] data32_from_slave,
    output logic        SCK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        SSEL
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LOW,
        SHIFT_HIGH,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] RELOAD     = 8'(CLOCK_DIVIDE - 1);
    localparam logic [5:0] LAST_BIT   = 6'd55;
    localparam logic [5:0] FIRST_DATA = 6'd24;
    localparam logic [5:0] GAP_LAST   = 6'(GAP_HALF_PERIODS - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [5:0]  bit_q, bit_d;
    logic [55:0] frame_q, frame_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] dout_q, dout_d;
    logic        sck_q, sck_d;
    logic        mosi_q, mosi_d;
    logic        ssel_q, ssel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tick;

    assign tick = (cnt_q == 8'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 6'd0;
            frame_q <= 56'd0;
            rx_q    <= 32'd0;
            dout_q  <= 32'd0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            ssel_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            ssel_q  <= ssel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:       if (start) state_d = SHIFT_LOW;
            SHIFT_LOW:  if (tick) state_d = SHIFT_HIGH;
            SHIFT_HIGH: if (tick) state_d = (bit_q == LAST_BIT) ? HOLD : SHIFT_LOW;
            HOLD:       if (tick) state_d = GAP;
            GAP:        if (tick && bit_q == GAP_LAST) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        ssel_d  = ssel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q != IDLE) begin
            cnt_d = tick ? RELOAD : cnt_q - 8'd1;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = RELOAD;
                    bit_d   = 6'd0;
                    frame_d = {command8, address16, data32};
                    mosi_d  = command8[7];
                    sck_d   = 1'b0;
                    ssel_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            SHIFT_LOW: begin
                if (tick) sck_d = 1'b1;
            end
            SHIFT_HIGH: begin
                if (tick) begin
                    sck_d = 1'b0;
                    // Command and address reply bits carry nothing useful.
                    if (bit_q >= FIRST_DATA) rx_d = {rx_q[30:0], MISO};
                    if (bit_q == LAST_BIT) begin
                        mosi_d = 1'b0;
                    end else begin
                        frame_d = {frame_q[54:0], 1'b0};
                        mosi_d  = frame_q[54];
                        bit_d   = bit_q + 6'd1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    ssel_d = 1'b1;
                    done_d = 1'b1;
                    dout_d = rx_q;
                    bit_d  = 6'd0;
                end
            end
            GAP: begin
                // The bit counter is reused to count gap half-periods.
                if (tick) begin
                    if (bit_q == GAP_LAST) begin
                        busy_d = 1'b0;
                        bit_d  = 6'd0;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
            default: begin
                sck_d  = 1'b0;
                ssel_d = 1'b1;
                busy_d = 1'b0;
            end
        endcase
    end

    assign SCK               = sck_q;
    assign MOSI              = mosi_q;
    assign SSEL              = ssel_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign data32_from_slave = dout_q;

endmodule
